// File: rtl/data_mem_unit.sv
// Data-memory stage: byte/half/word loads and stores with a fixed access latency,
// a valid/ready request handshake, and misalignment/range error reporting.
module data_mem_unit #(
  parameter int XLEN         = 32,
  parameter int DEPTH_WORDS  = 128,
  parameter int LATENCY      = 1,
  parameter int INIT_PATTERN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic            addr_src,
  input  logic            wdata_src,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [XLEN-1:0] aluout,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [XLEN:0] MEM_BYTES = (XLEN + 1)'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              req_ready_reg;
  logic              busy_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [XLEN-1:0]   resp_rdata_reg;
  logic [XLEN-1:0]   hold_rdata_reg;
  logic              hold_err_reg;

  logic              accept;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              req_err;
  logic              store_en;
  logic [IDX_W-1:0]  word_idx;
  logic [4:0]        lane_shift;
  logic [XLEN-1:0]   rd_word;
  logic [XLEN-1:0]   rd_shifted;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN-1:0]   ld_result;
  logic [XLEN-1:0]   wmask;
  logic [XLEN-1:0]   wdata_lane;
  logic [XLEN-1:0]   mem_words [DEPTH_WORDS];

  assign accept     = req_valid && (state_reg == ST_IDLE);
  assign addr       = addr_src ? data1 : aluout;
  assign wdata      = wdata_src ? aluout : data2;
  assign word_idx   = addr[IDX_W+1:2];
  assign lane_shift = {addr[1:0], 3'b000};
  assign store_en   = accept && req_we && !req_err;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = addr[0];
      2'd2:    req_err = (addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
    if ({1'b0, addr} >= MEM_BYTES) begin
      req_err = 1'b1;
    end
  end

  // Store lanes: data and mask are shifted into the addressed byte position.
  always_comb begin
    wmask = '0;
    case (req_size)
      2'd0:    wmask = {{(XLEN-8){1'b0}}, 8'hFF} << lane_shift;
      2'd1:    wmask = {{(XLEN-16){1'b0}}, 16'hFFFF} << lane_shift;
      default: wmask = '1;
    endcase
    wdata_lane = wdata << lane_shift;
  end

  // Each word is its own register so it can carry a power-up value without a reset.
  generate
    for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
      logic [XLEN-1:0] word_reg = (INIT_PATTERN != 0) ? XLEN'(gi) : '0;

      always_ff @(posedge clk) begin
        if (store_en && (word_idx == IDX_W'(gi))) begin
          word_reg <= (word_reg & ~wmask) | (wdata_lane & wmask);
        end
      end

      assign mem_words[gi] = word_reg;
    end
  endgenerate

  assign rd_word    = mem_words[word_idx];
  assign rd_shifted = rd_word >> lane_shift;

  always_comb begin
    ld_data = rd_word;
    case (req_size)
      2'd0: ld_data = req_unsigned ? {{(XLEN-8){1'b0}}, rd_shifted[7:0]}
                                   : {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: ld_data = req_unsigned ? {{(XLEN-16){1'b0}}, rd_shifted[15:0]}
                                   : {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      default: ld_data = rd_word;
    endcase
    ld_result = (req_we || req_err) ? '0 : ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      req_ready_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      hold_rdata_reg <= '0;
      hold_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            req_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            hold_rdata_reg <= ld_result;
            hold_err_reg   <= req_err;
            cnt_reg        <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata_reg <= ld_result;
              resp_err_reg   <= req_err;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg      <= ST_RESP;
            resp_valid_reg <= 1'b1;
            resp_rdata_reg <= hold_rdata_reg;
            resp_err_reg   <= hold_err_reg;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
          req_ready_reg  <= 1'b1;
          busy_reg       <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign busy       = busy_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: a LATENCY=1 instance driven from a vector table
// and a LATENCY=3 instance for latency, sampling and mid-operation reset sequences.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst1, rst3, v1, v3;
  logic        we, uns, asrc, wsrc;
  logic [1:0]  size;
  logic [31:0] d1, d2, alu;

  logic        rdy1, rv1, err1, busy1;
  logic [31:0] rdata1;
  logic        rdy3, rv3, err3, busy3;
  logic [31:0] rdata3;

  always #5 clk = ~clk;

  data_mem_unit #(.XLEN(32), .DEPTH_WORDS(128), .LATENCY(1), .INIT_PATTERN(1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_size(size), .req_unsigned(uns), .addr_src(asrc), .wdata_src(wsrc),
    .data1(d1), .data2(d2), .aluout(alu), .resp_valid(rv1), .resp_rdata(rdata1),
    .resp_err(err1), .busy(busy1)
  );

  data_mem_unit #(.XLEN(32), .DEPTH_WORDS(128), .LATENCY(3), .INIT_PATTERN(1)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we),
    .req_size(size), .req_unsigned(uns), .addr_src(asrc), .wdata_src(wsrc),
    .data1(d1), .data2(d2), .aluout(alu), .resp_valid(rv3), .resp_rdata(rdata3),
    .resp_err(err3), .busy(busy3)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic        asrc;
    logic        wsrc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] alu;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t ld(input logic [1:0] sz, input logic u, input logic [31:0] a,
                              input logic [31:0] exp, input logic e);
    vec_t v;
    v.we = 1'b0; v.size = sz; v.uns = u; v.asrc = 1'b0; v.wsrc = 1'b0;
    v.d1 = 32'h0BAD_0BAD; v.d2 = 32'h5A5A_5A5A; v.alu = a;
    v.exp_rdata = exp; v.exp_err = e;
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] data, input logic e);
    vec_t v;
    v.we = 1'b1; v.size = sz; v.uns = 1'b0; v.asrc = 1'b0; v.wsrc = 1'b0;
    v.d1 = 32'h0BAD_0BAD; v.d2 = data; v.alu = a;
    v.exp_rdata = 32'h0; v.exp_err = e;
    return v;
  endfunction

  // One full request/response transaction on the selected instance.
  task automatic run_op(input bit which, input vec_t v, input int id);
    int lat;
    @(negedge clk);
    we = v.we; size = v.size; uns = v.uns; asrc = v.asrc; wsrc = v.wsrc;
    d1 = v.d1; d2 = v.d2; alu = v.alu;
    chk($sformatf("op%0d ready_idle", id), 32'(which ? rdy3 : rdy1), 32'd1);
    if (which) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    alu = ~alu; d1 = ~d1; d2 = ~d2; size = ~size; uns = ~uns; we = ~we;
    lat = 1;
    while (!(which ? rv3 : rv1) && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("op%0d latency", id), 32'(lat), which ? 32'd3 : 32'd1);
    chk($sformatf("op%0d rdata", id), which ? rdata3 : rdata1, v.exp_rdata);
    chk($sformatf("op%0d err", id), 32'(which ? err3 : err1), 32'(v.exp_err));
    chk($sformatf("op%0d ready_resp", id), 32'(which ? rdy3 : rdy1), 32'd0);
    chk($sformatf("op%0d busy_resp", id), 32'(which ? busy3 : busy1), 32'd1);
    $display("op %0d dut_lat%0d we=%0b size=%0d A=0x%08h rdata=0x%08h err=%0b",
             id, which ? 3 : 1, v.we, v.size, v.asrc ? v.d1 : v.alu,
             which ? rdata3 : rdata1, which ? err3 : err1);
    @(posedge clk); #1;
    chk($sformatf("op%0d valid_clear", id), 32'(which ? rv3 : rv1), 32'd0);
    chk($sformatf("op%0d rdata_clear", id), which ? rdata3 : rdata1, 32'd0);
    chk($sformatf("op%0d ready_back", id), 32'(which ? rdy3 : rdy1), 32'd1);
  endtask

  initial begin
    int spurious;
    vec_t v;
    rst1 = 1'b0; rst3 = 1'b0; v1 = 1'b0; v3 = 1'b0;
    we = 1'b0; uns = 1'b0; asrc = 1'b0; wsrc = 1'b0; size = 2'd0;
    d1 = '0; d2 = '0; alu = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready1", 32'(rdy1), 32'd1);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst valid1", 32'(rv1), 32'd0);
    chk("rst rdata1", rdata1, 32'd0);
    chk("rst err1", 32'(err1), 32'd0);
    chk("rst ready3", 32'(rdy3), 32'd1);
    chk("rst busy3", 32'(busy3), 32'd0);
    $display("reset released");
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1;

    tbl[0]  = ld(2'd2, 1'b0, 32'd8,   32'h0000_0002, 1'b0);
    tbl[1]  = st(2'd0, 32'd5,   32'h0000_00AB, 1'b0);
    tbl[2]  = ld(2'd2, 1'b0, 32'd4,   32'h0000_AB01, 1'b0);
    tbl[3]  = st(2'd2, 32'd4,   32'h8001_0000, 1'b0);
    tbl[4]  = ld(2'd1, 1'b0, 32'd6,   32'hFFFF_8001, 1'b0);
    tbl[5]  = ld(2'd1, 1'b1, 32'd6,   32'h0000_8001, 1'b0);
    tbl[6]  = ld(2'd0, 1'b0, 32'd7,   32'hFFFF_FF80, 1'b0);
    tbl[7]  = ld(2'd0, 1'b1, 32'd6,   32'h0000_0001, 1'b0);
    tbl[8]  = ld(2'd2, 1'b0, 32'd2,   32'h0, 1'b1);
    tbl[9]  = st(2'd2, 32'd512, 32'h0000_DEAD, 1'b1);
    tbl[10] = ld(2'd2, 1'b0, 32'd0,   32'h0, 1'b0);
    tbl[11] = ld(2'd1, 1'b0, 32'd1,   32'h0, 1'b1);
    tbl[12] = ld(2'd3, 1'b0, 32'd0,   32'h0, 1'b1);
    v = st(2'd2, 32'h55, 32'h99, 1'b0);
    v.asrc = 1'b1; v.wsrc = 1'b1; v.d1 = 32'd12;
    tbl[13] = v;
    tbl[14] = ld(2'd2, 1'b0, 32'd12,  32'h0000_0055, 1'b0);
    tbl[15] = st(2'd1, 32'd18,  32'h1234_CDEF, 1'b0);
    tbl[16] = ld(2'd2, 1'b0, 32'd16,  32'hCDEF_0004, 1'b0);
    tbl[17] = ld(2'd0, 1'b0, 32'd19,  32'hFFFF_FFCD, 1'b0);
    tbl[18] = st(2'd2, 32'd10,  32'hFFFF_FFFF, 1'b1);
    tbl[19] = ld(2'd2, 1'b0, 32'd8,   32'h0000_0002, 1'b0);
    tbl[20] = ld(2'd2, 1'b0, 32'd508, 32'h0000_007F, 1'b0);
    v = ld(2'd2, 1'b0, 32'hFFFF_FF00, 32'h0000_0005, 1'b0);
    v.asrc = 1'b1; v.d1 = 32'd20;
    tbl[21] = v;
    v = st(2'd0, 32'd3, 32'hFFFF_FF90, 1'b0);
    v.uns = 1'b1;
    tbl[22] = v;
    tbl[23] = ld(2'd2, 1'b0, 32'd0,   32'h9000_0000, 1'b0);
    tbl[24] = ld(2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);

    for (int i = 0; i < 25; i++) begin
      run_op(1'b0, tbl[i], i);
    end

    // Request held through RESP must not be taken until the unit is back in IDLE.
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; asrc = 1'b0; wsrc = 1'b0; alu = 32'd8;
    v1 = 1'b1;
    @(posedge clk); #1;
    chk("hold first_resp", 32'(rv1), 32'd1);
    chk("hold first_rdata", rdata1, 32'h0000_0002);
    @(posedge clk); #1;
    chk("hold no_accept_in_resp", 32'(rv1), 32'd0);
    chk("hold ready_idle", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    chk("hold second_resp", 32'(rv1), 32'd1);
    v1 = 1'b0;
    $display("held request: second response rdata=0x%08h", rdata1);
    @(posedge clk); #1;
    chk("hold done", 32'(rv1), 32'd0);

    run_op(1'b1, st(2'd2, 32'd24, 32'hCAFE_F00D, 1'b0), 100);
    run_op(1'b1, ld(2'd2, 1'b0, 32'd24, 32'hCAFE_F00D, 1'b0), 101);

    // Reset while the load is in WAIT: the response must be dropped.
    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; asrc = 1'b0; wsrc = 1'b0; alu = 32'd24;
    v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("abort busy_wait", 32'(busy3), 32'd1);
    chk("abort no_early_resp", 32'(rv3), 32'd0);
    @(negedge clk);
    rst3 = 1'b0;
    @(posedge clk); #1;
    chk("abort busy_after_rst", 32'(busy3), 32'd0);
    chk("abort ready_after_rst", 32'(rdy3), 32'd1);
    chk("abort valid_after_rst", 32'(rv3), 32'd0);
    chk("abort rdata_after_rst", rdata3, 32'd0);
    @(negedge clk);
    rst3 = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rv3) spurious++;
    end
    chk("abort no_resp_after_rst", 32'(spurious), 32'd0);
    $display("abort sequence: spurious responses=%0d", spurious);

    run_op(1'b1, ld(2'd2, 1'b0, 32'd24, 32'hCAFE_F00D, 1'b0), 102);
    run_op(1'b1, ld(2'd2, 1'b0, 32'd20, 32'h0000_0005, 1'b0), 103);
    run_op(1'b1, ld(2'd1, 1'b0, 32'd26, 32'hFFFF_CAFE, 1'b0), 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
